// File: rtl/turf_hsk_pkg.sv
// Shared definitions for the TURF UDP housekeeping serial bridge.
// Holds the readout FSM states, UDP header layout and payload-length helper.
package turf_hsk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READY,
        ST_SHIFT,
        ST_DRAIN
    } hsk_state_t;

    localparam int UDP_HDR_LEN = 8;
    localparam int IP_LSB      = 32;
    localparam int PORT_LSB    = 16;
    localparam int LEN_WIDTH   = 12;

    // udp_length counts the 8-byte UDP header; only the remainder is payload.
    function automatic logic [LEN_WIDTH-1:0] udp_payload_len(input logic [LEN_WIDTH-1:0] udp_len);
        return (udp_len > LEN_WIDTH'(UDP_HDR_LEN)) ? udp_len - LEN_WIDTH'(UDP_HDR_LEN) : '0;
    endfunction

endpackage

// File: rtl/turf_hsk_sclk_edge.sv
// Two-flop history and edge strobes for the asynchronous housekeeping sclk/cs_b pins.
// Shared between the housekeeping read and write paths.
module turf_hsk_sclk_edge
    import turf_hsk_pkg::*;
(
    input  logic aclk,
    input  logic areset,
    input  logic sclk,
    input  logic cs_b,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic cs_low
);

    logic [1:0] sclk_hist;
    logic [1:0] cs_hist;

    always_ff @(posedge aclk) begin
        if (areset) begin
            sclk_hist <= '0;
            cs_hist   <= '0;
        end else begin
            sclk_hist <= {sclk_hist[0], sclk};
            cs_hist   <= {cs_hist[0], cs_b};
        end
    end

    // Bit 1 is the older sample, so 2'b10 is a high-to-low transition.
    always_comb begin
        sclk_fall = (sclk_hist == 2'b10);
        cs_fall   = (cs_hist == 2'b10);
        cs_rise   = (cs_hist == 2'b01);
        cs_low    = ~cs_hist[0];
    end

endmodule

// File: rtl/turf_udp_hsk_read.sv
// Bridges a received UDP housekeeping packet to a serial readout master.
// Header/payload arrive over AXI-Stream; bytes are shifted out MSB first on sclk falls.
module turf_udp_hsk_read
    import turf_hsk_pkg::*;
#(
    parameter DEBUG = "TRUE"
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [63:0] s_udphdr_tdata,
    input  logic        s_udphdr_tvalid,
    output logic        s_udphdr_tready,
    input  logic [63:0] s_udpdata_tdata,
    input  logic [7:0]  s_udpdata_tkeep,
    input  logic        s_udpdata_tlast,
    input  logic        s_udpdata_tvalid,
    output logic        s_udpdata_tready,
    input  logic        sclk,
    input  logic        cs_b,
    output logic        miso,
    output logic        irq_o,
    output logic [31:0] ip_o,
    output logic [15:0] port_o,
    output logic        underrun_o
);

    hsk_state_t state;
    hsk_state_t state_nxt;

    logic sclk_fall;
    logic cs_fall;
    logic cs_rise;
    logic cs_low;

    logic [63:0]          hold;
    logic [7:0]           keep;
    logic                 last_seen;
    logic                 word_valid;
    logic                 past_last;
    logic                 byte_blank;
    logic [2:0]           byte_idx;
    logic [2:0]           bit_idx;
    logic [LEN_WIDTH-1:0] bytes_left;

    logic need_word;
    logic shift_take;
    logic tlast_done;
    logic bit_step;
    logic byte_zero;
    logic unused_hdr_bits;

    turf_hsk_sclk_edge u_edge (
        .aclk      (aclk),
        .areset    (areset),
        .sclk      (sclk),
        .cs_b      (cs_b),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .cs_low    (cs_low)
    );

    assign unused_hdr_bits = ^s_udphdr_tdata[PORT_LSB-1:LEN_WIDTH];

    always_comb begin
        need_word  = (state == ST_SHIFT) && !word_valid;
        shift_take = need_word && s_udpdata_tvalid;
        tlast_done = last_seen || (shift_take && s_udpdata_tlast);
        // CS_RISE wins over a coincident SCLK_FALL.
        bit_step   = sclk_fall && cs_low && !cs_rise;
        byte_zero  = (bytes_left == '0) || !keep[byte_idx] || past_last
                     || !word_valid || byte_blank;
    end

    always_ff @(posedge aclk) begin
        if (areset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        s_udphdr_tready  = 1'b0;
        s_udpdata_tready = 1'b0;
        irq_o            = 1'b0;
        miso             = 1'b0;
        unique case (state)
            ST_IDLE: begin
                s_udphdr_tready = 1'b1;
                if (s_udphdr_tvalid) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                s_udpdata_tready = 1'b1;
                if (s_udpdata_tvalid) state_nxt = ST_READY;
            end
            ST_READY: begin
                irq_o = 1'b1;
                if (cs_fall) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                s_udpdata_tready = shift_take;
                miso             = ~byte_zero & hold[{byte_idx, bit_idx}];
                if (cs_rise) state_nxt = tlast_done ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: begin
                s_udpdata_tready = 1'b1;
                if (s_udpdata_tvalid && s_udpdata_tlast) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (areset) begin
            s_udphdr_tready  = 1'b0;
            s_udpdata_tready = 1'b0;
            irq_o            = 1'b0;
            miso             = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            ip_o       <= '0;
            port_o     <= '0;
            underrun_o <= 1'b0;
            hold       <= '0;
            keep       <= '0;
            last_seen  <= 1'b0;
            word_valid <= 1'b0;
            past_last  <= 1'b0;
            byte_blank <= 1'b0;
            byte_idx   <= '0;
            bit_idx    <= '0;
            bytes_left <= '0;
        end else begin
            underrun_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s_udphdr_tvalid) begin
                        ip_o       <= s_udphdr_tdata[IP_LSB +: 32];
                        port_o     <= s_udphdr_tdata[PORT_LSB +: 16];
                        bytes_left <= udp_payload_len(s_udphdr_tdata[LEN_WIDTH-1:0]);
                    end
                end
                ST_LOAD: begin
                    if (s_udpdata_tvalid) begin
                        hold       <= s_udpdata_tdata;
                        keep       <= s_udpdata_tkeep;
                        last_seen  <= s_udpdata_tlast;
                        word_valid <= 1'b1;
                        past_last  <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (cs_fall) begin
                        byte_idx   <= '0;
                        bit_idx    <= 3'd7;
                        byte_blank <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (bit_step) begin
                        // A byte is committed once its MSB has been clocked out; a
                        // word arriving later only serves the following bytes.
                        if (bit_idx == 3'd7 && !word_valid && !past_last) begin
                            underrun_o <= 1'b1;
                            byte_blank <= 1'b1;
                        end
                        if (bit_idx == 3'd0) begin
                            bit_idx    <= 3'd7;
                            byte_idx   <= byte_idx + 3'd1;
                            byte_blank <= 1'b0;
                            if (bytes_left != '0) bytes_left <= bytes_left - LEN_WIDTH'(1);
                            if (byte_idx == 3'd7) begin
                                if (last_seen) past_last  <= 1'b1;
                                else           word_valid <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx - 3'd1;
                        end
                    end
                    if (shift_take) begin
                        hold       <= s_udpdata_tdata;
                        keep       <= s_udpdata_tkeep;
                        last_seen  <= s_udpdata_tlast;
                        word_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    if (DEBUG == "TRUE") begin : g_debug
        // Hardware builds attach the ILA to sclk/cs_b/miso, state and counters here.
    end

endmodule

// File: doc/turf_udp_hsk_read.md
TURF_UDP_HSK_READ -- requirements
Module: turf_udp_hsk_read

Interface
REQ-001 Parameter: DEBUG, "TRUE", instantiates debug ILA on serial pins, state and counters when "TRUE".
REQ-002 aclk  in  1  sole clock; all logic on posedge.
REQ-003 areset  in  1  reset, synchronous, active-high.
REQ-004 s_udphdr_tdata  in  64  {ip[63:32], port[31:16], 4'b0, udp_length[11:0]}; udp_length includes the 8-byte UDP header.
REQ-005 s_udphdr_tvalid  in  1 / s_udphdr_tready  out  1  header handshake.
REQ-006 s_udpdata_tdata  in  64  payload word; byte n = tdata[8n+7:8n], byte 0 sent first.
REQ-007 s_udpdata_tkeep  in  8 / s_udpdata_tlast  in  1 / s_udpdata_tvalid  in  1 / s_udpdata_tready  out  1  payload handshake.
REQ-008 sclk  in  1  serial clock from housekeeping master, asynchronous.
REQ-009 cs_b  in  1  active-low select, asynchronous.
REQ-010 miso  out  1  serial data, MSB of each byte first.
REQ-011 irq_o  out  1  high while a packet is ready for readout.
REQ-012 ip_o  out  32 / port_o  out  16  source of last accepted header, held until next header.
REQ-013 underrun_o  out  1  one-cycle pulse when a byte is due but its payload word is not yet valid.

Function
REQ-014 sclk and cs_b SHALL each pass a 2-flop history; SCLK_FALL = history 2'b10, CS_FALL = 2'b10, CS_RISE = 2'b01.
REQ-015 FSM states: IDLE, LOAD, READY, SHIFT, DRAIN; reset state IDLE.
REQ-016 IDLE: s_udphdr_tready=1; on header handshake capture ip_o/port_o, load bytes_left = (udp_length>8) ? udp_length-8 : 0, go LOAD.
REQ-017 LOAD: s_udpdata_tready=1; on handshake load 64-bit hold register, tkeep, tlast flag; go READY.
REQ-018 READY: irq_o=1; on CS_FALL go SHIFT, byte index 0, bit index 7, miso = bit 7 of byte 0 the following cycle.
REQ-019 SHIFT: each SCLK_FALL with cs_b low advances bit index; after bit 0, byte index +1, bytes_left -1 (saturating at 0).
REQ-020 A byte SHALL output 0x00 if bytes_left==0, its tkeep bit is 0, or the word holding it came after tlast.
REQ-021 When byte index wraps 7->0 and tlast not yet seen, s_udpdata_tready=1 for exactly one cycle on the next valid word; no word consumed after tlast.
REQ-022 If a byte boundary is reached with its word not valid, pulse underrun_o, output 0x00 for that byte, keep waiting for the word.
REQ-023 CS_RISE in SHIFT: if tlast consumed go IDLE, else go DRAIN; CS_RISE SHALL take priority over a same-cycle SCLK_FALL.
REQ-024 DRAIN: s_udpdata_tready=1; discard words; on tlast handshake go IDLE.
REQ-025 CS_FALL in IDLE/LOAD SHALL be ignored; miso=0 there, irq_o=0.
REQ-026 Header and data tready SHALL never be high outside the states listed above.

Reset
REQ-027 While areset high: state IDLE, both treadys 0, miso 0, irq_o 0, underrun_o 0, ip_o 0, port_o 0, counters 0, histories 0.
REQ-028 Reset asserted mid-packet SHALL abandon the packet without draining; upstream is reset together.

Structure
REQ-029 Package turf_hsk_pkg SHALL hold the state enum, UDP_HDR_LEN=8, header field offsets (IP_LSB=32, PORT_LSB=16, LEN_WIDTH=12).
REQ-030 Sub-module turf_hsk_sclk_edge SHALL implement the history registers and edge strobes for sclk/cs_b, shared with the write path.

Verification
REQ-031 Header len=16, one word 0x0807060504030201 tkeep=FF tlast; 64 SCLK after cs_b fall -> miso bytes 01..08, irq_o drops at CS_FALL.
REQ-032 len=11, word tkeep=07 tlast; clock 6 bytes -> 01 02 03 00 00 00, no underrun.
REQ-033 len=40, 4 words, data tvalid withheld for word 2 -> underrun_o pulses once at byte 8, byte 8 = 0x00, later bytes correct.
REQ-034 len=40, 4 words, cs_b rises after 3 bytes -> DRAIN consumes remaining 3 words, returns to IDLE, next header accepted.
REQ-035 SCLK_FALL and CS_RISE in same cycle -> no bit advance, state exits SHIFT.
REQ-036 areset pulsed mid-SHIFT -> all outputs at reset values next cycle, s_udphdr_tready=1 once reset drops.
